seq_alu: RTL and testbench

Parametrised multi-cycle ALU that replaces the fixed 4-bit switch/LED combinational ALU in the board top level. It takes W-bit operands and a 3-bit opcode, and handles eight operations. Logic ops complete in one cycle; MUL and DIV are iterative over W cycles. Results are registered, with a start/busy/done handshake and status flags. The board top level drives it from switches/keys and shows result and flags on LEDs; any sequential controller can drive it the same way.

---
 rtl/seq_alu.sv | 174 +++++++++++++++++
 tb/tb_seq_alu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub/compare, iterative unsigned MUL and DIV
// with a start/busy/done handshake and registered result and status flags.
module seq_alu #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           zf,
    output logic           cf,
    output logic           vf,
    output logic           err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic [W-1:0]    quo, dvs, mp, rem;
    logic [2*W-1:0]  mc, acc;

    logic            accept, iter_go, single_go, last;
    logic signed [W-1:0] a_s, b_s;
    logic [W:0]      sum, dif;
    logic [2*W-1:0]  res_s;
    logic            cf_s, vf_s, err_s;

    logic [2*W-1:0]  acc_nxt, res_it;
    logic [W:0]      rem_sh, rem_dif;
    logic            qbit;
    logic [W-1:0]    rem_nxt, quo_nxt;

    // FIN doubles as an idle state so a new request is taken in the done cycle
    assign accept    = start && (state != ITER);
    assign iter_go   = accept && ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));
    assign single_go = accept && !iter_go;
    assign last      = (state == ITER) && (cnt == CNT_LAST);
    assign busy      = (state == ITER);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, FIN: state_nxt = iter_go ? ITER : IDLE;
            ITER:      if (last) state_nxt = FIN;
            default:   state_nxt = IDLE;
        endcase
    end

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} - {1'b0, b};
        res_s = '0;
        cf_s  = 1'b0;
        vf_s  = 1'b0;
        err_s = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_s = {{W{1'b0}}, sum[W-1:0]};
                cf_s  = sum[W];
                vf_s  = add_ovf(a[W-1], b[W-1], sum[W-1]);
            end
            OP_SUB: begin
                res_s = {{W{1'b0}}, dif[W-1:0]};
                cf_s  = dif[W];
                vf_s  = sub_ovf(a[W-1], b[W-1], dif[W-1]);
            end
            OP_AND:  res_s = {{W{1'b0}}, a & b};
            OP_OR:   res_s = {{W{1'b0}}, a | b};
            OP_XOR:  res_s = {{W{1'b0}}, a ^ b};
            OP_SLT:  res_s = {{(2*W-1){1'b0}}, (a_s < b_s)};
            // Only reached with b == 0: remainder = a, quotient saturates to all ones
            OP_DIV: begin
                res_s = {a, {W{1'b1}}};
                err_s = 1'b1;
            end
            default: res_s = '0;
        endcase
    end

    // One shift-add multiply step and one restoring divide step per ITER cycle
    assign acc_nxt = acc + (mp[0] ? mc : '0);
    assign rem_sh  = {rem, quo[W-1]};
    assign rem_dif = rem_sh - {1'b0, dvs};
    assign qbit    = ~rem_dif[W];
    assign rem_nxt = qbit ? rem_dif[W-1:0] : rem_sh[W-1:0];
    assign quo_nxt = {quo[W-2:0], qbit};
    assign res_it  = is_div ? {rem_nxt, quo_nxt} : acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            vf     <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (iter_go) begin
                cnt <= '0;
            end else if (busy) begin
                cnt <= cnt + CW'(1);
            end
            if (single_go) begin
                result <= res_s;
                zf     <= (res_s == '0);
                cf     <= cf_s;
                vf     <= vf_s;
                err    <= err_s;
                done   <= 1'b1;
            end else if (last) begin
                result <= res_it;
                zf     <= (res_it == '0);
                cf     <= 1'b0;
                vf     <= 1'b0;
                err    <= 1'b0;
                done   <= 1'b1;
            end
        end
    end

    // Iteration registers need no reset: they are always loaded on acceptance
    always_ff @(posedge clk) begin
        if (iter_go) begin
            is_div <= op[0];
            quo    <= a;
            dvs    <= b;
            mp     <= b;
            mc     <= {{W{1'b0}}, a};
            acc    <= '0;
            rem    <= '0;
        end else if (busy) begin
            acc <= acc_nxt;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at W=4: vector table plus handshake/reset sequences.
module tb_seq_alu;

    localparam int W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [7:0]   res;
        logic [3:0]   flg;   // {zf, cf, vf, err}
        int           lat;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     op = '0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done, zf, cf, vf, err;
    logic [2*W-1:0] result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_alu #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .zf(zf), .cf(cf), .vf(vf), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Issue one request, scramble the inputs after acceptance, wait for done.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int bcnt, output logic busy_at_done);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = ~x; b = ~y;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 3*W) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = 0;
        busy_at_done = busy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vq[$];
        int   lat, bc, extra;
        logic bd;

        vq.push_back('{"add_c_d",  OP_ADD, 4'hC, 4'hD, 8'h09, 4'b0100, 1});
        vq.push_back('{"sub_c_d",  OP_SUB, 4'hC, 4'hD, 8'h0F, 4'b0100, 1});
        vq.push_back('{"sub_7_8",  OP_SUB, 4'h7, 4'h8, 8'h0F, 4'b0110, 1});
        vq.push_back('{"add_7_1",  OP_ADD, 4'h7, 4'h1, 8'h08, 4'b0010, 1});
        vq.push_back('{"add_8_8",  OP_ADD, 4'h8, 4'h8, 8'h00, 4'b1110, 1});
        vq.push_back('{"div_d_0",  OP_DIV, 4'hD, 4'h0, 8'hDF, 4'b0001, 1});
        vq.push_back('{"and_c_a",  OP_AND, 4'hC, 4'hA, 8'h08, 4'b0000, 1});
        vq.push_back('{"or_c_a",   OP_OR,  4'hC, 4'hA, 8'h0E, 4'b0000, 1});
        vq.push_back('{"xor_c_a",  OP_XOR, 4'hC, 4'hA, 8'h06, 4'b0000, 1});
        vq.push_back('{"slt_c_a",  OP_SLT, 4'hC, 4'hA, 8'h00, 4'b1000, 1});
        vq.push_back('{"slt_a_c",  OP_SLT, 4'hA, 4'hC, 8'h01, 4'b0000, 1});
        vq.push_back('{"and_3_c",  OP_AND, 4'h3, 4'hC, 8'h00, 4'b1000, 1});
        vq.push_back('{"mul_c_d",  OP_MUL, 4'hC, 4'hD, 8'h9C, 4'b0000, W+1});
        vq.push_back('{"mul_f_f",  OP_MUL, 4'hF, 4'hF, 8'hE1, 4'b0000, W+1});
        vq.push_back('{"mul_0_5",  OP_MUL, 4'h0, 4'h5, 8'h00, 4'b1000, W+1});
        vq.push_back('{"div_d_4",  OP_DIV, 4'hD, 4'h4, 8'h13, 4'b0000, W+1});
        vq.push_back('{"div_f_1",  OP_DIV, 4'hF, 4'h1, 8'h0F, 4'b0000, W+1});
        vq.push_back('{"div_3_5",  OP_DIV, 4'h3, 4'h5, 8'h30, 4'b0000, W+1});

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, result, zf, cf, vf, err}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            run_op(vq[i].op, vq[i].a, vq[i].b, lat, bc, bd);
            check($sformatf("%s_latency", vq[i].name), lat, vq[i].lat);
            check($sformatf("%s_busy_cycles", vq[i].name), bc, (vq[i].lat == 1) ? 0 : W);
            check($sformatf("%s_busy_at_done", vq[i].name), bd, 1'b0);
            check($sformatf("%s_result", vq[i].name), result, vq[i].res);
            check($sformatf("%s_flags", vq[i].name), {zf, cf, vf, err}, vq[i].flg);
            @(posedge clk); #1;
            check($sformatf("%s_done_pulse", vq[i].name), done, 1'b0);
        end

        // Second start while busy must be ignored
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 4'hC; b = 4'hD;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 4'h0; b = 4'h0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 3*W) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore_latency", done ? lat : 0, W+1);
        check("ignore_result", result, 8'h9C);
        extra = 0;
        repeat (W+2) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("ignore_no_second_done", extra, 0);

        // New start accepted in the done cycle
        run_op(OP_MUL, 4'hB, 4'h7, lat, bc, bd);
        check("b2b_mul_result", result, 8'h4D);
        start = 1'b1; op = OP_ADD; a = 4'h1; b = 4'h2;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_add_done", {done, busy}, 2'b10);
        check("b2b_add_result", result, 8'h03);

        // Start held across consecutive cycles: one done per request
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 4'h1; b = 4'h1;
        @(posedge clk); #1;
        check("held_first", {done, result}, {1'b1, 8'h02});
        a = 4'h2; b = 4'h3;
        @(posedge clk); #1;
        start = 1'b0;
        check("held_second", {done, result}, {1'b1, 8'h05});

        // Reset in the second busy cycle of a MUL
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 4'hC; b = 4'hD;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midreset_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_outputs", {busy, done, result, zf, cf, vf, err}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (W+2) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("midreset_no_done", extra, 0);
        run_op(OP_MUL, 4'hB, 4'h7, lat, bc, bd);
        check("restart_latency", lat, W+1);
        check("restart_result", result, 8'h4D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
